tx_controller_mouth: RTL and testbench

Serial frame transmitter that feeds the receive side of the CRC network link. It accepts a payload of 1–15 bytes through a start pulse and serializes it onto a one-bit line. Frame format: preamble, SFD, destination/source address, length, payload, then CRC-8 over the payload. Bit order and framing match what the RX controller expects: MSB first, one bit per BIT_DIV clocks, line idles low.

---
 rtl/tx_controller_mouth.sv | 132 +++++++++++++
 tb/tb_tx_controller_mouth.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/tx_controller_mouth.sv
// tx_controller_mouth: serial frame transmitter (preamble, SFD, addr, len, payload, CRC-8), MSB first, idle-low line
// Ports: clk / rst_n            clock, asynchronous active-low reset
//        tx_start, tx_data,     frame request (sampled only in IDLE), payload in tx_data[8*len-1:0],
//        tx_len, dest_id, my_id length 1..15, destination and source node IDs
//        tx_line                registered serial line, one bit per BIT_DIV clocks
//        tx_busy                high from accept until the inter-frame gap ends
//        tx_done, tx_err        registered one-cycle pulses (first GAP cycle / rejected zero-length start)
//        fsm_state              {1'b0, state} debug view
module tx_controller_mouth #(
    parameter int BIT_DIV  = 1,
    parameter int IFG_BITS = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         tx_start,
    input  logic [127:0] tx_data,
    input  logic [3:0]   tx_len,
    input  logic [1:0]   dest_id,
    input  logic [1:0]   my_id,
    output logic         tx_line,
    output logic         tx_busy,
    output logic         tx_done,
    output logic         tx_err,
    output logic [3:0]   fsm_state
);
    typedef enum logic [2:0] {IDLE, PRE, SFD, ADDR, LEN, PAY, CRC, GAP} state_t;
    localparam logic [7:0] SFD_PAT = 8'hAB;
    state_t state_q, state_d;
    logic [7:0] div_q, div_d, cnt_q, cnt_d, crc_q, crc_d, crc_sh_q, crc_sh_d;
    logic [127:0] data_q, data_d;
    logic [3:0] len_q, len_d, addr_q, addr_d;
    logic line_q, line_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic tick, last, line_n, fb;
    logic [7:0] lim, last_cnt, cnt_n;
    assign tick = div_q == 8'(BIT_DIV - 1);
    assign lim = {1'b0, len_q, 3'b000} - 8'd1;
    assign last_cnt = state_q == PRE ? 8'd15 :
                      (state_q == SFD || state_q == CRC) ? 8'd7 :
                      (state_q == ADDR || state_q == LEN) ? 8'd3 :
                      state_q == PAY ? lim : 8'(IFG_BITS - 1);
    assign last = cnt_q == last_cnt;
    assign cnt_n = last ? 8'd0 : cnt_q + 8'd1;
    // Value of the bit that becomes visible after the next bit-time boundary.
    // CRC bits after the first come from the shadow copy so crc_q stays frozen.
    assign line_n = state_d == PRE  ? ~cnt_n[0] :
                    state_d == SFD  ? SFD_PAT[3'(8'd7 - cnt_n)] :
                    state_d == ADDR ? addr_q[2'(8'd3 - cnt_n)] :
                    state_d == LEN  ? len_q[2'(8'd3 - cnt_n)] :
                    state_d == PAY  ? data_q[7'(lim - cnt_n)] :
                    state_d == CRC  ? (cnt_n == 8'd0 ? crc_q[7] : crc_sh_q[7]) : 1'b0;
    assign fb = crc_q[7] ^ line_n;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            div_q    <= '0;
            cnt_q    <= '0;
            crc_q    <= '0;
            crc_sh_q <= '0;
            data_q   <= '0;
            len_q    <= '0;
            addr_q   <= '0;
            line_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            crc_q    <= crc_d;
            crc_sh_q <= crc_sh_d;
            data_q   <= data_d;
            len_q    <= len_d;
            addr_q   <= addr_d;
            line_q   <= line_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end
    // GAP + 1 wraps to IDLE in the 3-bit encoding.
    always_comb begin
        state_d = state_q;
        if (state_q == IDLE)
            state_d = (tx_start && tx_len != 4'd0) ? PRE : IDLE;
        else if (tick && last)
            state_d = state_t'(3'(state_q + 3'd1));
    end
    always_comb begin
        div_d    = div_q;
        cnt_d    = cnt_q;
        crc_d    = crc_q;
        crc_sh_d = crc_sh_q;
        data_d   = data_q;
        len_d    = len_q;
        addr_d   = addr_q;
        line_d   = line_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        if (state_q == IDLE) begin
            err_d = tx_start && tx_len == 4'd0;
            if (state_d == PRE) begin
                data_d = tx_data;
                len_d  = tx_len;
                addr_d = {dest_id, my_id};
                crc_d  = 8'h00;
                cnt_d  = 8'd0;
                div_d  = 8'd0;
                busy_d = 1'b1;
                line_d = 1'b1;
            end
        end else if (!tick) begin
            div_d = div_q + 8'd1;
        end else begin
            div_d  = 8'd0;
            cnt_d  = cnt_n;
            line_d = line_n;
            done_d = state_q == CRC && last;
            busy_d = state_d != IDLE;
            if (state_d == PAY)
                crc_d = {crc_q[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
            if (state_d == CRC)
                crc_sh_d = cnt_n == 8'd0 ? {crc_q[6:0], 1'b0} : {crc_sh_q[6:0], 1'b0};
        end
    end
    assign tx_line   = line_q;
    assign tx_busy   = busy_q;
    assign tx_done   = done_q;
    assign tx_err    = err_q;
    assign fsm_state = {1'b0, state_q};
endmodule

// File: tb/tb_tx_controller_mouth.sv
// tb_tx_controller_mouth: bit-exact frame check of tx_controller_mouth at BIT_DIV=1 and BIT_DIV=4
module tb_tx_controller_mouth;
    logic clk = 1'b0, rst_n = 1'b0, tx_start = 1'b0, sel4 = 1'b0;
    logic [127:0] tx_data = '0;
    logic [3:0] tx_len = '0;
    logic [1:0] dest_id = '0, my_id = '0;
    logic start1, start4, line1, busy1, done1, err1, line4, busy4, done4, err4;
    logic o_line, o_busy, o_done, o_err;
    logic [3:0] st1, st4, o_st;
    int checks = 0, failures = 0;
    bit expq[$];
    always #5 clk = ~clk;
    assign start1 = tx_start & ~sel4;
    assign start4 = tx_start & sel4;
    assign o_line = sel4 ? line4 : line1;
    assign o_busy = sel4 ? busy4 : busy1;
    assign o_done = sel4 ? done4 : done1;
    assign o_err  = sel4 ? err4 : err1;
    assign o_st   = sel4 ? st4 : st1;
    tx_controller_mouth #(.BIT_DIV(1), .IFG_BITS(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .tx_start(start1), .tx_data(tx_data), .tx_len(tx_len),
        .dest_id(dest_id), .my_id(my_id), .tx_line(line1), .tx_busy(busy1), .tx_done(done1),
        .tx_err(err1), .fsm_state(st1));
    tx_controller_mouth #(.BIT_DIV(4), .IFG_BITS(16)) dut4 (
        .clk(clk), .rst_n(rst_n), .tx_start(start4), .tx_data(tx_data), .tx_len(tx_len),
        .dest_id(dest_id), .my_id(my_id), .tx_line(line4), .tx_busy(busy4), .tx_done(done4),
        .tx_err(err4), .fsm_state(st4));
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    // Bytewise CRC-8 (poly 0x07, init 0, no reflection), bytes taken most significant first.
    function automatic logic [7:0] crc8(input logic [127:0] d, input int len);
        logic [7:0] c;
        c = 8'h00;
        for (int k = len - 1; k >= 0; k--) begin
            c ^= d[8*k +: 8];
            for (int j = 0; j < 8; j++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction
    function automatic logic [7:0] st_of(input int i, input int len);
        return i < 16 ? 8'd1 : i < 24 ? 8'd2 : i < 28 ? 8'd3 : i < 32 ? 8'd4 : i < 32 + 8*len ? 8'd5 : 8'd6;
    endfunction
    // Sends one frame and checks every cycle until it is back in IDLE.
    // inj pulses extra starts mid-payload, mid-gap and in the last gap cycle.
    task automatic send(input bit use4, input int len, input logic [127:0] data,
                        input logic [1:0] dst, input logic [1:0] my, input bit inj, input int exp_crc);
        int dv, nb, tot;
        logic [7:0] ec, cap, sfd;
        logic [3:0] l4;
        sfd = 8'hAB;
        l4 = 4'(len);
        ec = crc8(data, len);
        cap = 8'h00;
        dv = use4 ? 4 : 1;
        expq.delete();
        for (int k = 15; k >= 0; k--) expq.push_back(k % 2 == 1);
        for (int k = 7; k >= 0; k--) expq.push_back(sfd[k]);
        expq.push_back(dst[1]);
        expq.push_back(dst[0]);
        expq.push_back(my[1]);
        expq.push_back(my[0]);
        for (int k = 3; k >= 0; k--) expq.push_back(l4[k]);
        for (int k = 8*len - 1; k >= 0; k--) expq.push_back(data[k]);
        for (int k = 7; k >= 0; k--) expq.push_back(ec[k]);
        nb = expq.size();
        @(negedge clk);
        sel4 = use4;
        tx_data = data;
        tx_len = l4;
        dest_id = dst;
        my_id = my;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        for (int i = 0; i < nb; i++)
            for (int d = 0; d < dv; d++) begin
                chk($sformatf("line bit%0d", i), 8'(o_line), 8'(expq[i]));
                chk($sformatf("state bit%0d", i), 8'(o_st), st_of(i, len));
                chk("busy in frame", 8'(o_busy), 8'd1);
                chk("done/err in frame", {6'd0, o_done, o_err}, 8'd0);
                if (i >= nb - 8 && d == 0) cap = {cap[6:0], o_line};
                tx_start = inj && i == 34 && d == 0;
                if (tx_start) begin
                    tx_len = 4'($urandom_range(0, 15));
                    tx_data = {4{$urandom}};
                    dest_id = ~dst;
                end
                @(negedge clk);
            end
        if (exp_crc >= 0) chk("crc field", cap, 8'(exp_crc));
        tot = 16 * dv;
        for (int g = 0; g < tot; g++) begin
            chk($sformatf("gap line %0d", g), 8'(o_line), 8'd0);
            chk($sformatf("gap state %0d", g), 8'(o_st), 8'd7);
            chk("gap busy", 8'(o_busy), 8'd1);
            chk($sformatf("gap done %0d", g), 8'(o_done), 8'(g == 0));
            tx_start = inj && (g == 5 || g == tot - 1);
            if (tx_start) tx_len = 4'($urandom_range(1, 15));
            @(negedge clk);
        end
        tx_start = 1'b0;
        chk("idle state", 8'(o_st), 8'd0);
        chk("idle busy", 8'(o_busy), 8'd0);
        chk("idle line/done/err", {5'd0, o_line, o_done, o_err}, 8'd0);
        @(negedge clk);
        chk("still idle state", 8'(o_st), 8'd0);
        chk("still idle busy", 8'(o_busy), 8'd0);
    endtask
    initial begin
        repeat (2) @(negedge clk);
        chk("reset dut1", {line1, busy1, done1, err1, st1}, 8'd0);
        chk("reset dut4", {line4, busy4, done4, err4, st4}, 8'd0);
        rst_n = 1'b1;
        @(negedge clk);
        send(1'b0, 1, 128'h01, 2'd2, 2'd1, 1'b0, 8'h07);
        send(1'b0, 9, 128'h313233343536373839, 2'd1, 2'd3, 1'b0, 8'hF4);
        @(negedge clk);
        sel4 = 1'b0;
        tx_len = 4'd0;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        chk("zero len err pulse", 8'(err1), 8'd1);
        chk("zero len busy/line/state", {busy1, line1, 2'd0, st1}, 8'd0);
        @(negedge clk);
        chk("zero len err ends", 8'(err1), 8'd0);
        chk("zero len still idle", {busy1, line1, 2'd0, st1}, 8'd0);
        // CRC-8/0x07 of the single byte 0xA5 is 0x72.
        send(1'b1, 1, 128'hA5, 2'd0, 2'd3, 1'b0, 8'h72);
        send(1'b0, 3, {4{$urandom}}, 2'd3, 2'd0, 1'b1, -1);
        send(1'b0, 1, 128'h01, 2'd2, 2'd1, 1'b0, 8'h07);
        send(1'b1, 5, {4{$urandom}}, 2'd1, 2'd2, 1'b1, -1);
        @(negedge clk);
        sel4 = 1'b0;
        tx_data = 128'h01;
        tx_len = 4'd1;
        dest_id = 2'd2;
        my_id = 2'd1;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (35) @(negedge clk);
        chk("pre-reset in payload", 8'(st1), 8'd5);
        rst_n = 1'b0;
        #1;
        chk("async reset outputs", {line1, busy1, done1, err1, st1}, 8'd0);
        @(negedge clk);
        chk("held reset outputs", {line1, busy1, done1, err1, st1}, 8'd0);
        rst_n = 1'b1;
        send(1'b0, 1, 128'h01, 2'd2, 2'd1, 1'b0, 8'h07);
        for (int r = 0; r < 16; r++)
            send(1'($urandom_range(0, 1)), $urandom_range(1, 15), {4{$urandom}},
                 2'($urandom), 2'($urandom), r % 4 == 0, -1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
